// File: rtl/color_sequencer.sv
// Sweeps the colour sensor filters (R,G,B,C), captures one counter result per channel and classifies the dominant colour.
// Latency: 4*(SETTLE_CYCLES + W + 1) + 3 cycles per sweep, where W is the counter window; all outputs are registered.
// Backpressure: none; start is ignored while busy, and a missing freq_done is bounded by TIMEOUT_CYCLES.
module color_sequencer #(
    parameter int unsigned SETTLE_CYCLES  = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 8000000,
    parameter logic [32:0] CLEAR_MIN      = 33'd50,
    parameter logic [1:0]  SCALE          = 2'b10
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        continuous,
    input  logic [32:0] freq_in,
    input  logic        freq_done,
    output logic        freq_enable,
    output logic        s0,
    output logic        s1,
    output logic        s2,
    output logic        s3,
    output logic [32:0] red,
    output logic [32:0] green,
    output logic [32:0] blue,
    output logic [32:0] clear,
    output logic [1:0]  color_code,
    output logic        result_valid,
    output logic        busy,
    output logic        timeout_err
);

    // One shared cycle counter serves both the settle delay and the measure timeout.
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int          CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        MEASURE  = 3'd2,
        STORE    = 3'd3,
        CLASSIFY = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       ch;
    logic [1:0]       ch_nxt;
    logic [CNT_W-1:0] cyc_cnt;
    logic             cap_en;
    logic [32:0]      cap_dat;
    logic             tmo_set;
    logic             tmo_clr;
    logic [1:0]       code_nxt;

    // Channel order is R,G,B,C but the sensor encodes filters as red 00, blue 01, clear 10, green 11.
    function automatic logic [1:0] filter_sel(input logic [1:0] c);
        case (c)
            2'd0:    filter_sel = 2'b00;
            2'd1:    filter_sel = 2'b11;
            2'd2:    filter_sel = 2'b01;
            default: filter_sel = 2'b10;
        endcase
    endfunction

    // Scaling select is a static strap, unaffected by reset.
    assign s0 = SCALE[1];
    assign s1 = SCALE[0];

    // State and channel index registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ch    <= 2'd0;
        end else begin
            state <= state_nxt;
            ch    <= ch_nxt;
        end
    end

    // Next-state logic plus capture/timeout strobes for the datapath.
    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        cap_en    = 1'b0;
        cap_dat   = '0;
        tmo_set   = 1'b0;
        tmo_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETTLE;
                    ch_nxt    = 2'd0;
                    tmo_clr   = 1'b1;
                end
            end
            SETTLE: begin
                if (cyc_cnt == SETTLE_LAST) begin
                    state_nxt = MEASURE;
                end
            end
            MEASURE: begin
                if (freq_done) begin
                    cap_en    = 1'b1;
                    cap_dat   = freq_in;
                    state_nxt = STORE;
                end else if (cyc_cnt == TIMEOUT_LAST) begin
                    // Abort the channel: record zero so a stale count is never reused.
                    cap_en    = 1'b1;
                    tmo_set   = 1'b1;
                    state_nxt = STORE;
                end
            end
            STORE: begin
                if (ch == 2'd3) begin
                    state_nxt = CLASSIFY;
                end else begin
                    ch_nxt    = ch + 2'd1;
                    state_nxt = SETTLE;
                end
            end
            CLASSIFY: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (continuous) begin
                    state_nxt = SETTLE;
                    ch_nxt    = 2'd0;
                    tmo_clr   = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Dominant colour: too little light means no decision; ties favour red, then green.
    always_comb begin
        code_nxt = 2'd0;
        if (clear < CLEAR_MIN) begin
            code_nxt = 2'd0;
        end else if (red >= green && red >= blue) begin
            code_nxt = 2'd1;
        end else if (green >= blue) begin
            code_nxt = 2'd2;
        end else begin
            code_nxt = 2'd3;
        end
    end

    // Cycle counter restarts on every state change so each SETTLE/MEASURE is timed from entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt <= '0;
        end else if (state_nxt != state || !(state == SETTLE || state == MEASURE)) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CNT_ONE;
        end
    end

    // Registered outputs, decoded from the next state so they align with the state they describe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            freq_enable  <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            freq_enable  <= (state_nxt == MEASURE);
            busy         <= (state_nxt != IDLE);
            result_valid <= (state_nxt == DONE);
            if (state_nxt == SETTLE) begin
                {s2, s3} <= filter_sel(ch_nxt);
            end
            if (tmo_clr) begin
                timeout_err <= 1'b0;
            end else if (tmo_set) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Per-channel result capture; registers hold between sweeps.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
            clear <= '0;
        end else if (cap_en) begin
            case (ch)
                2'd0:    red   <= cap_dat;
                2'd1:    green <= cap_dat;
                2'd2:    blue  <= cap_dat;
                default: clear <= cap_dat;
            endcase
        end
    end

    // Colour code updates once per sweep, visible together with result_valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            color_code <= 2'd0;
        end else if (state == CLASSIFY) begin
            color_code <= code_nxt;
        end
    end

endmodule

// File: tb/tb_color_sequencer.sv
// Directed bench: behavioural frequency counter model with fixed per-filter counts.
// Latency: sweeps complete within a bounded cycle budget, checked against hand-computed results.
// Backpressure: none; the counter model answers freq_enable after a fixed window.
module tb_color_sequencer;

    localparam int W = 20;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        continuous;
    logic [32:0] freq_in;
    logic        freq_done;
    logic        freq_enable;
    logic        s0, s1, s2, s3;
    logic [32:0] red, green, blue, clear;
    logic [1:0]  color_code;
    logic        result_valid;
    logic        busy;
    logic        timeout_err;

    int n_checks = 0;
    int n_err    = 0;
    int rv_cnt   = 0;

    // Counter model state, indexed by filter code {s2,s3}.
    logic [32:0] cnt_by_filt [4];
    bit          dead_filt   [4];
    int          win;
    logic [1:0]  filt_q [$];

    color_sequencer #(
        .SETTLE_CYCLES (4),
        .TIMEOUT_CYCLES(50),
        .CLEAR_MIN     (33'd50),
        .SCALE         (2'b10)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .continuous  (continuous),
        .freq_in     (freq_in),
        .freq_done   (freq_done),
        .freq_enable (freq_enable),
        .s0          (s0),
        .s1          (s1),
        .s2          (s2),
        .s3          (s3),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .clear       (clear),
        .color_code  (color_code),
        .result_valid(result_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Filter codes: red 00, green 11, blue 01, clear 10.
    task automatic set_counts(input int r, input int g, input int b, input int c);
        cnt_by_filt[0] = 33'(r);
        cnt_by_filt[3] = 33'(g);
        cnt_by_filt[1] = 33'(b);
        cnt_by_filt[2] = 33'(c);
    endtask

    task automatic pulse_start();
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
    endtask

    task automatic wait_rv(input string tag);
        int n;
        n = 0;
        while (!result_valid && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check(tag, result_valid, 1);
    endtask

    task automatic check_counts(input string tag, input int r, input int g, input int b, input int c,
                                input int code);
        check({tag, ".red"},   red,   64'(r));
        check({tag, ".green"}, green, 64'(g));
        check({tag, ".blue"},  blue,  64'(b));
        check({tag, ".clear"}, clear, 64'(c));
        check({tag, ".code"},  color_code, 64'(code));
    endtask

    task automatic check_filt_seq(input string tag);
        logic [7:0] seq;
        seq = 8'h00;
        check({tag, ".nmeas"}, filt_q.size(), 4);
        if (filt_q.size() == 4) begin
            seq = {filt_q[0], filt_q[1], filt_q[2], filt_q[3]};
        end
        check({tag, ".filters"}, seq, 8'b00_11_01_10);
    endtask

    // Behavioural counter: counts W enabled cycles, then pulses freq_done once with the filter's count.
    initial begin
        freq_done = 1'b0;
        freq_in   = '0;
        win       = 0;
        forever begin
            @(posedge clock);
            #1;
            freq_done = 1'b0;
            if (freq_enable) begin
                win++;
                if (win == 1) filt_q.push_back({s2, s3});
                if (win == W && !dead_filt[{s2, s3}]) begin
                    freq_done = 1'b1;
                    freq_in   = cnt_by_filt[{s2, s3}];
                end
            end else begin
                win = 0;
            end
        end
    end

    always @(negedge clock) if (result_valid) rv_cnt++;

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        for (int i = 0; i < 4; i++) dead_filt[i] = 1'b0;
        set_counts(0, 0, 0, 0);
        repeat (3) @(negedge clock);
        check("rst.outs", {freq_enable, s2, s3, busy, result_valid, timeout_err}, 0);
        check("rst.scale", {s0, s1}, 2'b10);
        check("rst.counts", {red, green, blue, clear}, 0);
        check("rst.code", color_code, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Basic sweep, red dominant.
        set_counts(400, 100, 50, 600);
        filt_q.delete();
        rv_cnt = 0;
        pulse_start();
        check("t1.busy", busy, 1);
        check("t1.settle", {freq_enable, s2, s3}, 0);
        wait_rv("t1.rv");
        check_counts("t1", 400, 100, 50, 600, 1);
        repeat (3) @(negedge clock);
        check("t1.idle", busy, 0);
        check("t1.rvcnt", rv_cnt, 1);
        check_filt_seq("t1");

        // Red/green tie resolves to red.
        set_counts(300, 300, 10, 600);
        pulse_start();
        wait_rv("t2a.rv");
        check_counts("t2a", 300, 300, 10, 600, 1);
        repeat (2) @(negedge clock);

        set_counts(300, 300, 900, 600);
        pulse_start();
        wait_rv("t2b.rv");
        check_counts("t2b", 300, 300, 900, 600, 3);
        repeat (2) @(negedge clock);

        // Too little clear light: no colour.
        set_counts(500, 100, 50, 20);
        pulse_start();
        wait_rv("t3.rv");
        check_counts("t3", 500, 100, 50, 20, 0);
        repeat (2) @(negedge clock);

        // Blue channel times out.
        set_counts(100, 200, 777, 600);
        dead_filt[1] = 1'b1;
        pulse_start();
        wait_rv("t4.rv");
        check_counts("t4", 100, 200, 0, 600, 2);
        check("t4.tmo", timeout_err, 1);
        repeat (2) @(negedge clock);
        check("t4.tmo_hold", timeout_err, 1);
        dead_filt[1] = 1'b0;
        set_counts(100, 200, 300, 600);
        pulse_start();
        check("t4.tmo_clr", timeout_err, 0);
        wait_rv("t4b.rv");
        check_counts("t4b", 100, 200, 300, 600, 3);
        repeat (2) @(negedge clock);

        // Continuous mode: back-to-back sweeps, stray starts ignored.
        continuous = 1'b1;
        set_counts(10, 700, 20, 600);
        rv_cnt = 0;
        pulse_start();
        repeat (30) @(negedge clock);
        pulse_start();
        wait_rv("t5a.rv");
        check_counts("t5a", 10, 700, 20, 600, 2);
        @(negedge clock);
        continuous = 1'b0;
        check("t5.resettle", {busy, freq_enable, s2, s3}, 4'b1000);
        set_counts(10, 20, 800, 600);
        repeat (40) @(negedge clock);
        pulse_start();
        wait_rv("t5b.rv");
        check_counts("t5b", 10, 20, 800, 600, 3);
        repeat (10) @(negedge clock);
        check("t5.idle", busy, 0);
        check("t5.rvcnt", rv_cnt, 2);

        // Reset during green MEASURE.
        set_counts(111, 222, 333, 600);
        pulse_start();
        begin
            int n;
            n = 0;
            while (!(freq_enable && {s2, s3} == 2'b11) && n < 500) begin
                @(negedge clock);
                n++;
            end
            check("t6.green_meas", {freq_enable, s2, s3}, 3'b111);
        end
        reset_n = 1'b0;
        #1;
        check("t6.outs", {freq_enable, s2, s3, busy, result_valid, timeout_err}, 0);
        check("t6.counts", {red, green, blue, clear}, 0);
        check("t6.code", color_code, 0);
        check("t6.scale", {s0, s1}, 2'b10);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("t6.idle", busy, 0);
        set_counts(50, 60, 70, 600);
        filt_q.delete();
        pulse_start();
        check("t6.start_red", {busy, s2, s3}, 3'b100);
        wait_rv("t6.rv");
        check_counts("t6", 50, 60, 70, 600, 3);
        check_filt_seq("t6");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
